// File: rtl/divclk_tick_counter_if.sv
// Control/status bundle between the divider-driven tick counter and its user.
// master drives the controls, slave is the counter itself.
interface divclk_tick_counter_if #(
    parameter int WIDTH = 8
);
    logic             div_clk_in;
    logic             en;
    logic             up_dn;
    logic             one_shot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc_pulse;
    logic             done;

    modport master (
        output div_clk_in, en, up_dn, one_shot, load, load_val,
        input  count, tc_pulse, done
    );

    modport slave (
        input  div_clk_in, en, up_dn, one_shot, load, load_val,
        output count, tc_pulse, done
    );
endinterface

// File: rtl/divclk_tick_counter.sv
// Counts rising edges of the divider output (sampled as data in the clk domain),
// up/down modulo MAX_COUNT+1 with load and one-shot modes.
// Optional build macro TICK_CNT_SAT_EN: saturate at the limits instead of wrapping.
module divclk_tick_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    divclk_tick_counter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [1:0]       state;
    logic             div_q;
    logic [WIDTH-1:0] count;
    logic             tc_q;
    logic             tick;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] nxt;
    logic             at_term;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        tick         = bus.div_clk_in & ~div_q;
        term         = bus.up_dn ? MAX_V : '0;
        at_term      = (count == term);
        // Only used when not already at the limit, so it never leaves 0..MAX_COUNT.
        nxt          = bus.up_dn ? count + 1'b1 : count - 1'b1;
        load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            tc_q  <= 1'b0;
            div_q <= bus.div_clk_in;   // no phantom edge right after release
        end else begin
            div_q <= bus.div_clk_in;
            tc_q  <= 1'b0;
            if (bus.load) begin
                count <= load_clamped;
                state <= bus.en ? RUN : IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.en) state <= RUN;
                    RUN: begin
                        if (!bus.en) begin
                            state <= IDLE;
                        end else if (tick) begin
                            if (bus.one_shot) begin
                                if (!at_term) count <= nxt;
                                if (at_term || nxt == term) begin
                                    state <= DONE;
                                    tc_q  <= 1'b1;
                                end
                            end else begin
`ifdef TICK_CNT_SAT_EN
                                if (!at_term) begin
                                    count <= nxt;
                                    tc_q  <= (nxt == term);
                                end
`else
                                count <= at_term ? (bus.up_dn ? '0 : MAX_V) : nxt;
                                tc_q  <= at_term;
`endif
                            end
                        end
                    end
                    DONE:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.count    = count;
    assign bus.tc_pulse = tc_q;
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_divclk_tick_counter.sv
// Randomized + directed bench for divclk_tick_counter against a cycle-level
// behavioural model (MAX_COUNT=9, non-power-of-two modulus).
module tb_divclk_tick_counter;
    localparam int W = 8;
    localparam int M = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    divclk_tick_counter_if #(.WIDTH(W)) bus ();

    divclk_tick_counter #(.WIDTH(W), .MAX_COUNT(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int   m_cnt   = 0;
    logic m_tc    = 1'b0;
    logic m_done  = 1'b0;
    logic m_run   = 1'b0;
    logic m_prev  = 1'b0;

    task automatic model_update();
        logic tick, at_term;
        int   lv;
        if (!rst_n) begin
            m_cnt = 0; m_tc = 0; m_done = 0; m_run = 0; m_prev = bus.div_clk_in;
            return;
        end
        tick   = bus.div_clk_in && !m_prev;
        m_prev = bus.div_clk_in;
        m_tc   = 0;
        if (bus.load) begin
            lv     = int'(bus.load_val);
            m_cnt  = (lv > M) ? M : lv;
            m_done = 0;
            m_run  = bus.en;
            return;
        end
        if (m_done) return;
        if (!m_run) begin m_run = bus.en; return; end
        if (!bus.en) begin m_run = 0; return; end
        if (!tick) return;
        at_term = bus.up_dn ? (m_cnt == M) : (m_cnt == 0);
        if (bus.one_shot) begin
            if (!at_term) m_cnt = bus.up_dn ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == (bus.up_dn ? M : 0)) begin m_done = 1; m_tc = 1; end
        end else begin
`ifdef TICK_CNT_SAT_EN
            if (!at_term) begin
                m_cnt = bus.up_dn ? m_cnt + 1 : m_cnt - 1;
                m_tc  = (m_cnt == (bus.up_dn ? M : 0));
            end
`else
            m_cnt = bus.up_dn ? (m_cnt + 1) % (M + 1) : (m_cnt + M) % (M + 1);
            m_tc  = at_term;
`endif
        end
    endtask

    // Drive one cycle of inputs at negedge, advance the model, land just after posedge.
    task automatic apply(input logic r, input logic d, input logic e, input logic u,
                         input logic o, input logic l, input logic [W-1:0] lv);
        @(negedge clk);
        rst_n = r; bus.div_clk_in = d; bus.en = e; bus.up_dn = u;
        bus.one_shot = o; bus.load = l; bus.load_val = lv;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(0, 1, 1, 1, 0, 0, 0);
        apply(0, 1, 1, 1, 0, 0, 0);
        total++;
        if (bus.count !== 8'd0 || bus.tc_pulse !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: got cnt=%0d tc=%b done=%b want 0/0/0", bus.count, bus.tc_pulse, bus.done);
        end
        for (int i = 0; i < 3; i++) apply(1, 1, 1, 1, 0, 0, 0);
        total++;
        if (bus.count !== 8'd0) begin
            bad++; $display("FAIL reset_no_tick: got cnt=%0d want 0", bus.count);
        end
        apply(1, 0, 1, 1, 0, 0, 0);
        apply(1, 1, 1, 1, 0, 0, 0);
        total++;
        if (bus.count !== 8'd1 || int'(bus.count) !== m_cnt) begin
            bad++; $display("FAIL reset_first_edge: got cnt=%0d want 1 (model %0d)", bus.count, m_cnt);
        end
    endtask

    task automatic test_count_up();
        int tcs = 0;
        apply(1, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 48; i++) begin
            apply(1, (i % 4) < 2, 1, 1, 0, 0, 0);
            total++;
            if (int'(bus.count) !== m_cnt || bus.tc_pulse !== m_tc || bus.done !== m_done) begin
                bad++;
                $display("FAIL count_up cyc %0d: got cnt=%0d tc=%b done=%b want cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc_pulse, bus.done, m_cnt, m_tc, m_done);
            end
            if (bus.tc_pulse) tcs++;
        end
        total++;
        if (bus.count !== 8'd2 || tcs !== 1) begin
            bad++; $display("FAIL count_up_end: got cnt=%0d tc_pulses=%0d want 2/1", bus.count, tcs);
        end
    endtask

    task automatic test_wrap_down();
        apply(1, 0, 1, 0, 0, 1, 0);
        apply(1, 1, 1, 0, 0, 0, 0);
        total++;
        if (bus.count !== 8'd9 || bus.tc_pulse !== 1'b1) begin
            bad++; $display("FAIL wrap_down: got cnt=%0d tc=%b want 9/1", bus.count, bus.tc_pulse);
        end
        apply(1, 1, 1, 0, 0, 0, 0);
        total++;
        if (bus.tc_pulse !== 1'b0 || bus.count !== 8'd9) begin
            bad++; $display("FAIL wrap_down_pulse_len: got cnt=%0d tc=%b want 9/0", bus.count, bus.tc_pulse);
        end
    endtask

    task automatic test_one_shot();
        int tcs = 0;
        apply(1, 0, 1, 1, 1, 1, 7);
        for (int i = 0; i < 20; i++) begin
            apply(1, (i % 4) < 2, 1, 1, (i < 12), 0, 0);  // one_shot drops while DONE
            total++;
            if (int'(bus.count) !== m_cnt || bus.tc_pulse !== m_tc || bus.done !== m_done) begin
                bad++;
                $display("FAIL one_shot cyc %0d: got cnt=%0d tc=%b done=%b want cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc_pulse, bus.done, m_cnt, m_tc, m_done);
            end
            if (bus.tc_pulse) tcs++;
        end
        total++;
        if (bus.count !== 8'd9 || bus.done !== 1'b1 || tcs !== 1) begin
            bad++; $display("FAIL one_shot_hold: got cnt=%0d done=%b tcs=%0d want 9/1/1", bus.count, bus.done, tcs);
        end
        apply(1, 0, 1, 1, 0, 1, 2);
        total++;
        if (bus.count !== 8'd2 || bus.done !== 1'b0 || bus.tc_pulse !== 1'b0) begin
            bad++; $display("FAIL one_shot_reload: got cnt=%0d done=%b tc=%b want 2/0/0", bus.count, bus.done, bus.tc_pulse);
        end
    endtask

    task automatic test_load_tick();
        apply(1, 0, 1, 1, 0, 0, 0);
        apply(1, 1, 1, 1, 0, 1, 200);
        total++;
        if (bus.count !== 8'd9 || bus.tc_pulse !== 1'b0 || int'(bus.count) !== m_cnt) begin
            bad++; $display("FAIL load_clamp: got cnt=%0d tc=%b want 9/0", bus.count, bus.tc_pulse);
        end
        apply(1, 0, 1, 1, 0, 0, 0);
        total++;
        if (bus.count !== 8'd9 || bus.tc_pulse !== 1'b0) begin
            bad++; $display("FAIL load_tick_dropped: got cnt=%0d tc=%b want 9/0", bus.count, bus.tc_pulse);
        end
    endtask

    task automatic test_limit();
        int tcs = 0;
        int exp_end;
        apply(1, 0, 1, 1, 0, 1, 6);
        for (int i = 0; i < 24; i++) begin
            apply(1, (i % 4) < 2, 1, 1, 0, 0, 0);
            total++;
            if (int'(bus.count) !== m_cnt || bus.tc_pulse !== m_tc || bus.done !== m_done) begin
                bad++;
                $display("FAIL limit cyc %0d: got cnt=%0d tc=%b done=%b want cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc_pulse, bus.done, m_cnt, m_tc, m_done);
            end
            if (bus.tc_pulse) tcs++;
        end
`ifdef TICK_CNT_SAT_EN
        exp_end = 9;
`else
        exp_end = 2;
`endif
        total++;
        if (int'(bus.count) !== exp_end || tcs !== 1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL limit_end: got cnt=%0d tcs=%0d done=%b want %0d/1/0", bus.count, tcs, bus.done, exp_end);
        end
    endtask

    task automatic test_en_gating();
        apply(1, 0, 0, 1, 0, 1, 4);
        apply(1, 1, 0, 1, 0, 0, 0);   // IDLE: edge ignored
        apply(1, 0, 1, 1, 0, 0, 0);   // IDLE->RUN
        apply(1, 1, 0, 1, 0, 0, 0);   // edge with en low: ignored
        total++;
        if (bus.count !== 8'd4) begin
            bad++; $display("FAIL en_gating: got cnt=%0d want 4", bus.count);
        end
    endtask

    task automatic test_random();
        logic d = 0, e = 1, u = 1, o = 0, r, l;
        logic [W-1:0] lv;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) d = ~d;
            if ($urandom_range(0, 15) == 0) e = ~e;
            if ($urandom_range(0, 31) == 0) u = ~u;
            if ($urandom_range(0, 47) == 0) o = ~o;
            r  = ($urandom_range(0, 99) != 0);
            l  = ($urandom_range(0, 29) == 0);
            lv = W'($urandom_range(0, 255));
            apply(r, d, e, u, o, l, lv);
            total++;
            if (int'(bus.count) !== m_cnt || bus.tc_pulse !== m_tc || bus.done !== m_done) begin
                bad++;
                $display("FAIL random cyc %0d: got cnt=%0d tc=%b done=%b want cnt=%0d tc=%b done=%b",
                         i, bus.count, bus.tc_pulse, bus.done, m_cnt, m_tc, m_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 0, 1, 1, 1, 1, 5);
        apply(1, 1, 1, 1, 1, 1, 3);
        apply(0, 0, 1, 1, 1, 1, 8);
        total++;
        if (bus.count !== 8'd0 || bus.tc_pulse !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got cnt=%0d tc=%b done=%b want 0/0/0", bus.count, bus.tc_pulse, bus.done);
        end
    endtask

    initial begin
        rst_n = 0; bus.div_clk_in = 0; bus.en = 0; bus.up_dn = 1;
        bus.one_shot = 0; bus.load = 0; bus.load_val = '0;
        test_reset();
        test_count_up();
        test_wrap_down();
        test_one_shot();
        test_load_tick();
        test_limit();
        test_en_gating();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
